// File: rtl/dijkstra_pkg.sv
// Shared types and default sizing for the Dijkstra datapath: graph size,
// RAM geometry, the INF distance encoding and the scan FSM state type.
package dijkstra_pkg;

    localparam int N_NODES = 32;
    localparam int ADDR_W  = 5;
    localparam int DIST_W  = 8;
    localparam int RD_LAT  = 2;

    // All-ones distance marks an unreachable node.
    localparam logic [DIST_W-1:0] INF = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

endpackage : dijkstra_pkg

// File: rtl/rd_lat_pipe.sv
// DEPTH-stage {valid, index} delay line that tags synchronous-RAM read data
// with the address that produced it. Reusable by any RAM consumer.
module rd_lat_pipe
    import dijkstra_pkg::*;
#(
    parameter int IDX_W = ADDR_W,
    parameter int DEPTH = RD_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_idx [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the chain shifts by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // NOTE: only the valid bits are reset; an index is never looked at while
    // its valid is low, so the index storage stays reset-free.
    always_ff @(posedge clk) begin
        r_idx[0] <= i_idx;
        for (int i = 1; i < DEPTH; i++) begin
            r_idx[i] <= r_idx[i-1];
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];

endmodule : rd_lat_pipe

// File: rtl/min_dist_finder.sv
// Scans the distance RAM for the unvisited node with the smallest finite
// distance. Define MIN_FINDER_CAND_CNT_EN to add the o_cand_cnt output.
module min_dist_finder
    import dijkstra_pkg::*;
#(
    parameter int N_NODES = dijkstra_pkg::N_NODES,
    parameter int ADDR_W  = dijkstra_pkg::ADDR_W,
    parameter int DIST_W  = dijkstra_pkg::DIST_W,
    parameter int RD_LAT  = dijkstra_pkg::RD_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [N_NODES-1:0] i_visited,
    output logic [ADDR_W-1:0]  o_rd_addr,
    input  logic [DIST_W-1:0]  i_rd_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_found,
    output logic [ADDR_W-1:0]  o_min_node,
    output logic [DIST_W-1:0]  o_min_dist
`ifdef MIN_FINDER_CAND_CNT_EN
    ,
    output logic [ADDR_W:0]    o_cand_cnt
`endif
);

    localparam logic [DIST_W-1:0] L_INF  = '1;
    localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(N_NODES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_NODES-1:0]  r_vis;
    logic [ADDR_W-1:0]   r_addr;

    logic                r_best_ok;
    logic [ADDR_W-1:0]   r_best_node;
    logic [DIST_W-1:0]   r_best_dist;
    logic                w_best_ok_nxt;
    logic [ADDR_W-1:0]   w_best_node_nxt;
    logic [DIST_W-1:0]   w_best_dist_nxt;

    logic                r_found;
    logic [ADDR_W-1:0]   r_min_node;
    logic [DIST_W-1:0]   r_min_dist;

    logic                w_accept;
    logic                w_issue;
    logic                w_pipe_valid;
    logic [ADDR_W-1:0]   w_pipe_idx;
    logic                w_qualify;
    logic                w_take;
    logic                w_finish;

    assign w_accept = (r_state == IDLE) && i_start;
    assign w_issue  = (r_state == SCAN);

    rd_lat_pipe #(
        .IDX_W (ADDR_W),
        .DEPTH (RD_LAT)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue),
        .i_idx   (r_addr),
        .o_valid (w_pipe_valid),
        .o_idx   (w_pipe_idx)
    );

    // Strict less-than keeps the earliest index on ties.
    assign w_qualify = w_pipe_valid && !r_vis[w_pipe_idx] && (i_rd_data != L_INF);
    assign w_take    = w_qualify && (!r_best_ok || (i_rd_data < r_best_dist));

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_best_ok_nxt   = r_best_ok;
        w_best_node_nxt = r_best_node;
        w_best_dist_nxt = r_best_dist;
        if (w_take) begin
            w_best_ok_nxt   = 1'b1;
            w_best_node_nxt = w_pipe_idx;
            w_best_dist_nxt = i_rd_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_nxt = SCAN;
            SCAN:    if (r_addr == L_LAST) w_state_nxt = DRAIN;
            DRAIN:   if (w_pipe_valid && (w_pipe_idx == L_LAST)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The last compare and the result load share one edge.
    assign w_finish = (r_state == DRAIN) && (w_state_nxt == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vis  <= '0;
            r_addr <= '0;
        end else if (w_accept) begin
            r_vis  <= i_visited;
            r_addr <= '0;
        end else if (w_issue && (r_addr != L_LAST)) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_best_ok   <= 1'b0;
            r_best_node <= '0;
            r_best_dist <= L_INF;
        end else begin
            r_best_ok   <= w_best_ok_nxt;
            r_best_node <= w_best_node_nxt;
            r_best_dist <= w_best_dist_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_found    <= 1'b0;
            r_min_node <= '0;
            r_min_dist <= L_INF;
        end else if (w_finish) begin
            r_found    <= w_best_ok_nxt;
            r_min_node <= w_best_node_nxt;
            r_min_dist <= w_best_dist_nxt;
        end
    end

`ifdef MIN_FINDER_CAND_CNT_EN
    logic [ADDR_W:0] r_cand_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_cand_cnt <= '0;
        end else if (w_qualify) begin
            r_cand_cnt <= r_cand_cnt + 1'b1;
        end
    end

    assign o_cand_cnt = r_cand_cnt;
`endif

    assign o_rd_addr  = r_addr;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);
    assign o_found    = r_found;
    assign o_min_node = r_min_node;
    assign o_min_dist = r_min_dist;

endmodule : min_dist_finder

// File: doc/min_dist_finder.md
Name: min_dist_finder

Overview:
- Scan engine directly upstream of the 32x8 distance RAM. It drives the RAM read address and consumes the RAM read data.
- On `start`, it walks node addresses 0..N_NODES-1. It skips visited nodes and returns the unvisited node with the smallest finite tentative distance.
- The Dijkstra controller uses the result as the next node to relax.

Parameters:
- N_NODES, 32, number of graph nodes (RAM depth); must be 2..2**ADDR_W.
- ADDR_W, 5, RAM address width.
- DIST_W, 8, distance width; all-ones value is INF (unreachable).
- RD_LAT, 2, RAM read latency in cycles: address presented in cycle c gives data valid in cycle c+RD_LAT.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- visited  in  N_NODES  visited mask; bit i=1 means node i is excluded; sampled on the accepted start cycle
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  DIST_W  RAM read data
- busy  out  1  high from the cycle after an accepted start until done, inclusive
- done  out  1  one-cycle pulse; results valid from this cycle until the next accepted start
- found  out  1  at least one unvisited node has distance != INF
- min_node  out  ADDR_W  index of minimum; 0 when found=0
- min_dist  out  DIST_W  minimum distance; INF when found=0

Behaviour:
- Reset values: rd_addr=0, busy=0, done=0, found=0, min_node=0, min_dist=all-ones, FSM=IDLE, pipeline valids cleared.
- A reset mid-scan aborts immediately with no done pulse.
- FSM states:
  - IDLE: when start=1, capture visited into vis_q, clear the running minimum (best_dist=INF, best_node=0, best_ok=0), then go to SCAN.
  - SCAN: rd_addr = issue counter, starting at 0 in the first SCAN cycle and incrementing by 1 each cycle. After issuing N_NODES-1, go to DRAIN.
  - DRAIN: hold rd_addr; wait until the last data returns and has been compared, then go to DONE.
  - DONE: done=1 for one cycle, update the result outputs, return to IDLE.
- Alignment: an RD_LAT-deep shift register carries {valid, index} alongside each issued address. When the shifted valid=1, rd_data belongs to the shifted index.
- Compare rule, applied in each cycle with valid data: the candidate qualifies if vis_q[index]=0 and rd_data != INF.
  - If it qualifies and (best_ok=0 or rd_data < best_dist), update best_dist, best_node and set best_ok=1.
  - Comparison is strict, so ties keep the lowest index.
  - Unsigned arithmetic only; no adder in this block.
- Latency with defaults: start sampled in cycle 0, addresses in cycles 1..32, last data in cycle 34, done in cycle 35. General form: done = N_NODES+RD_LAT+1 cycles after start.
- start while busy is ignored. Changes on `visited` after the start cycle have no effect.
- start in the same cycle as done is ignored; start is accepted the following cycle.
- Result outputs hold their values between scans.
- Boundary cases:
  - All nodes visited, or all unvisited nodes at INF: found=0, min_node=0, min_dist=INF.
  - Node 0 is the only candidate: found=1, min_node=0.
  - Index N_NODES-1 is compared (no off-by-one at wrap); the issue counter never exceeds N_NODES-1.

Optional Feature:
- Macro: MIN_FINDER_CAND_CNT_EN.
- Defined: adds output cand_cnt (ADDR_W+1 bits).
  - Counts qualifying candidates in the current scan.
  - Cleared on accepted start and on reset; valid at done; held until the next start.
  - Saturates cannot occur, since the maximum is N_NODES.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package dijkstra_pkg holds:
  - ADDR_W, DIST_W, N_NODES;
  - INF constant (all-ones DIST_W);
  - FSM state enum {IDLE, SCAN, DRAIN, DONE}.
- One natural sub-module, rd_lat_pipe: an RD_LAT-deep {valid, index} delay line with synchronous reset, reusable by other RAM consumers.

Test Plan:
- Bench setup: behavioural 32x8 RAM with 2-cycle read latency.
- Scenarios:
  - RAM = {0:0, 1:5, 2:3, rest INF}, visited=0x00000001, start → done in cycle 35 with found=1, min_node=2, min_dist=3; busy high cycles 1..35.
  - Ties: node 7=4 and node 20=4, all others INF, visited=0 → min_node=7, min_dist=4.
  - Last node: only node 31=9 finite, visited=0x7FFFFFFF... set so node 31 is unvisited → min_node=31, min_dist=9 (checks the end-of-scan boundary).
  - All visited (visited=0xFFFFFFFF), or all-INF with visited=0 → found=0, min_node=0, min_dist=255.
  - start pulsed in cycle 10 of a scan, and visited changed mid-scan → ignored, same result as the first scenario. Then assert rst in cycle 20 of a new scan → no done; outputs at reset values; next start produces a correct result.
  - With MIN_FINDER_CAND_CNT_EN and the first scenario's data → cand_cnt=2. Without the macro → the design compiles with no cand_cnt port.
